// File: rtl/spi_pkg.sv
// Shared definitions for the SPI primary, its dummy secondary and benches.
package spi_pkg;

  // Primary controller FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StHold,
    StGap
  } spi_state_t;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam logic SpiCpol = 1'b0;
  localparam logic SpiCpha = 1'b0;

  localparam int unsigned SpiDataW  = 8;
  localparam int unsigned SpiClkDiv = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 while enabled, tick on the last count.
// Holding en low parks the counter at 0 so every transfer starts on a fresh half-period.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Wrap at CntMax; clear whenever disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == CntMax)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = en && (cnt_q == CntMax);

endmodule

// File: rtl/spi_primary.sv
// Mode-0 SPI primary with start/busy/done handshake and one active-low select per secondary.
// Optional build macro SPI_PRIMARY_LSB_FIRST_EN: shift both directions LSB first
// (default is MSB first). All outputs are registered and change together with the FSM state.
module spi_primary
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = SpiDataW,
  parameter int unsigned CLK_DIV = SpiClkDiv,
  parameter int unsigned NUM_CS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic [$clog2(NUM_CS)-1:0] cs_sel,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      done,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  output logic [NUM_CS-1:0]         cs
);

  localparam int unsigned CS_W = $clog2(NUM_CS);
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  spi_state_t        state_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [BitW-1:0]   bit_q;
  logic              tick;
  logic              div_en;
  logic [NUM_CS-1:0] cs_dec;
  logic              tx_first;
  logic              tx_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  // Half-period timing only runs during a transfer.
  assign div_en = (state_q != StIdle);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .tick(tick)
  );

  // Select decode; an out-of-range index leaves every select deasserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

`ifdef SPI_PRIMARY_LSB_FIRST_EN
  assign tx_first = tx_data[0];
  assign tx_next  = tx_sr_q[1];
  assign tx_shift = {1'b0, tx_sr_q[DATA_W-1:1]};
  assign rx_shift = {miso, rx_sr_q[DATA_W-1:1]};
`else
  assign tx_first = tx_data[DATA_W-1];
  assign tx_next  = tx_sr_q[DATA_W-2];
  assign tx_shift = {tx_sr_q[DATA_W-2:0], 1'b0};
  assign rx_shift = {rx_sr_q[DATA_W-2:0], miso};
`endif

  // Transfer FSM with shift registers, bit counter and registered SPI/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      bit_q   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= SpiCpol;
      mosi    <= 1'b0;
      cs      <= '1;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSetup;
            tx_sr_q <= tx_data;
            bit_q   <= '0;
            busy    <= 1'b1;
            cs      <= cs_dec;
            mosi    <= tx_first;
          end
        end
        StSetup: begin
          if (tick) begin
            state_q <= StShiftHi;
            sclk    <= ~SpiCpol;
            rx_sr_q <= rx_shift;
          end
        end
        StShiftHi: begin
          if (tick) begin
            state_q <= StShiftLo;
            sclk    <= SpiCpol;
            tx_sr_q <= tx_shift;
            mosi    <= tx_next;
          end
        end
        StShiftLo: begin
          if (tick) begin
            if (bit_q == LastBit) begin
              state_q <= StHold;
            end else begin
              state_q <= StShiftHi;
              bit_q   <= bit_q + BitW'(1);
              sclk    <= ~SpiCpol;
              rx_sr_q <= rx_shift;
            end
          end
        end
        StHold: begin
          if (tick) begin
            state_q <= StGap;
            cs      <= '1;
          end
        end
        StGap: begin
          if (tick) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr_q;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
